// File: rtl/pll_clk_sel_ctrl_if.sv
// rtl/pll_clk_sel_ctrl_if.sv - PLL config bus (req/ack register access) between host and clock-select controller
interface pll_clk_sel_ctrl_if;
    logic        cfg_req_i;
    logic        cfg_wrn_i;
    logic [1:0]  cfg_add_i;
    logic [31:0] cfg_data_i;
    logic        cfg_ack_o;
    logic [31:0] cfg_r_data_o;

    modport master (
        output cfg_req_i, cfg_wrn_i, cfg_add_i, cfg_data_i,
        input  cfg_ack_o, cfg_r_data_o
    );

    modport slave (
        input  cfg_req_i, cfg_wrn_i, cfg_add_i, cfg_data_i,
        output cfg_ack_o, cfg_r_data_o
    );
endinterface

// File: rtl/pll_clk_sel_ctrl.sv
// rtl/pll_clk_sel_ctrl.sv - glitch-free PLL clock select sequencer with config register file
module pll_clk_sel_ctrl #(
    parameter int NUM_CLK       = 5,
    parameter int SEL_W         = $clog2(NUM_CLK),
    parameter int DEFAULT_SEL   = 2,
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic                   ref_clk_i,
    input  logic                   rst_i,
    input  logic                   pll_lock_i,
    pll_clk_sel_ctrl_if.slave      cfg,
    output logic [SEL_W-1:0]       sel_o,
    output logic                   clk_en_o,
    output logic                   cfg_lock_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_SETTLE,
        S_WAIT_LOCK
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   pend_q, pend_d;
    logic               en_q, en_d;
    logic               clk_en_q, clk_en_d;
    logic               lock_q, lock_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [15:0]        timeout_q, timeout_d;
    logic [15:0]        to_act_q, to_act_d;
    logic               to_err_q, to_err_d;
    logic               sel_err_q, sel_err_d;

    logic               sel_wr;
    logic               accept;
    logic               to_set;
    logic               sel_set;
    logic               clr_to;
    logic               clr_sel;
    logic [31:0]        rd_mux;

    // A SEL write is held off while sequencing so the pending select is never overwritten.
    assign sel_wr = cfg.cfg_wrn_i && (cfg.cfg_add_i == 2'd0);
    assign accept = cfg.cfg_req_i && !ack_q && !(sel_wr && (state_q != S_IDLE));

    always_comb begin
        rd_mux = 32'd0;
        case (cfg.cfg_add_i)
            2'd0: rd_mux[SEL_W-1:0] = sel_q;
            2'd1: begin
                rd_mux[0]          = pll_lock_i;
                rd_mux[1]          = busy_q;
                rd_mux[2]          = to_err_q;
                rd_mux[3]          = sel_err_q;
                rd_mux[8 +: SEL_W] = sel_q;
            end
            2'd2: rd_mux[15:0] = timeout_q;
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        pend_d    = pend_q;
        en_d      = en_q;
        clk_en_d  = clk_en_q;
        ack_d     = 1'b0;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        to_act_d  = to_act_q;
        to_set    = 1'b0;
        sel_set   = 1'b0;
        clr_to    = 1'b0;
        clr_sel   = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_en_d = pll_lock_i && en_q;
            end
            S_GATE: begin
                clk_en_d = 1'b0;
                if (cnt_q == 16'(GATE_CYCLES - 1)) begin
                    sel_d   = pend_q;
                    cnt_d   = 16'd0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                clk_en_d = 1'b0;
                if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                    cnt_d    = 16'd0;
                    to_act_d = timeout_q;
                    state_d  = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                clk_en_d = 1'b0;
                if (pll_lock_i) begin
                    en_d    = 1'b1;
                    state_d = S_IDLE;
                end else if ((to_act_q != 16'd0) && (cnt_q + 16'd1 == to_act_q)) begin
                    to_set  = 1'b1;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase

        if (accept) begin
            ack_d   = 1'b1;
            rdata_d = rd_mux;
            if (cfg.cfg_wrn_i) begin
                case (cfg.cfg_add_i)
                    2'd0: begin
                        if (cfg.cfg_data_i >= 32'(NUM_CLK)) begin
                            sel_set = 1'b1;
                        end else if (cfg.cfg_data_i != 32'(sel_q)) begin
                            pend_d   = cfg.cfg_data_i[SEL_W-1:0];
                            cnt_d    = 16'd0;
                            clk_en_d = 1'b0;
                            state_d  = S_GATE;
                        end
                    end
                    2'd2: timeout_d = cfg.cfg_data_i[15:0];
                    2'd3: begin
                        clr_to  = cfg.cfg_data_i[0];
                        clr_sel = cfg.cfg_data_i[1];
                    end
                    default: ;
                endcase
            end
        end

        to_err_d  = (to_err_q && !clr_to) || to_set;
        sel_err_d = (sel_err_q && !clr_sel) || sel_set;
        lock_d    = clk_en_q && pll_lock_i;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= 16'd0;
            sel_q     <= SEL_W'(DEFAULT_SEL);
            pend_q    <= SEL_W'(DEFAULT_SEL);
            en_q      <= 1'b0;
            clk_en_q  <= 1'b0;
            lock_q    <= 1'b0;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
            timeout_q <= 16'(LOCK_TIMEOUT);
            to_act_q  <= 16'(LOCK_TIMEOUT);
            to_err_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            clk_en_q  <= clk_en_d;
            lock_q    <= lock_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            to_act_q  <= to_act_d;
            to_err_q  <= to_err_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_o            = sel_q;
    assign clk_en_o         = clk_en_q;
    assign cfg_lock_o       = lock_q;
    assign busy_o           = busy_q;
    assign cfg.cfg_ack_o    = ack_q;
    assign cfg.cfg_r_data_o = rdata_q;

endmodule
